// File: rtl/vga_palette_banked.sv
`default_nettype none
// ============================================================================
// Module   : vga_palette_banked
// Purpose  : Multi-bank palette lookup with frame-synchronised bank swap and
//            a per-frame brightness fade. Fixed 2-cycle pixel latency.
//            Optional readback port: define VGA_PALETTE_READBACK_EN.
// Revision : 1.0  initial release
// ============================================================================
module vga_palette_banked #(
    parameter int PIXEL_BITS = 8,
    parameter int NUM_BANKS  = 2,
    parameter int CHAN_BITS  = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     hwregs_write,
    input  logic [11:0]              hwregs_addr,
    input  logic [31:0]              hwregs_wdata,
`ifdef VGA_PALETTE_READBACK_EN
    input  logic                     hwregs_read,
    output logic [31:0]              hwregs_rdata,
`endif
    input  logic                     frame_start,
    input  logic                     pixel_valid,
    input  logic [PIXEL_BITS-1:0]    pixel_in,
    output logic                     rgb_valid,
    output logic [3*CHAN_BITS-1:0]   rgb,
    output logic [7:0]               status
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int RGB_BITS  = 3 * CHAN_BITS;
    localparam int ADDR_BITS = BANK_BITS + PIXEL_BITS;
    localparam int DEPTH     = NUM_BANKS * (2 ** PIXEL_BITS);

    localparam logic [11:0] c_addr_ctrl   = 12'h800;
    localparam logic [11:0] c_addr_bright = 12'h804;
    localparam logic [11:0] c_addr_fade   = 12'h808;

    logic [BANK_BITS-1:0]  r_write_bank;
    logic [BANK_BITS-1:0]  r_pending_bank;
    logic [BANK_BITS-1:0]  r_display_bank;
    logic                  r_swap_pending;
    logic [7:0]            r_brightness;
    logic [7:0]            r_fade_target;
    logic [7:0]            r_fade_step;

    logic                  r_valid1;
    logic [7:0]            r_bright1;
    logic [RGB_BITS-1:0]   r_entry;
    logic                  r_rgb_valid;
    logic [RGB_BITS-1:0]   r_rgb;

    logic [RGB_BITS-1:0]   r_palette [0:DEPTH-1];

    logic                  w_wr_pal;
    logic                  w_wr_ctrl;
    logic                  w_wr_bright;
    logic                  w_wr_fade;
    logic                  w_swap_go;
    logic [BANK_BITS-1:0]  w_pending_nxt;
    logic [ADDR_BITS-1:0]  w_wr_addr;
    logic [ADDR_BITS-1:0]  w_rd_addr;
    logic [8:0]            w_sum;
    logic [8:0]            w_diff;
    logic [7:0]            w_fade_next;
    logic [8:0]            w_bright_p1;
    logic [RGB_BITS-1:0]   w_scaled;
    logic [2:0]            w_disp_bank3;
    logic                  w_unused;

    assign w_wr_pal    = hwregs_write && !hwregs_addr[11];
    assign w_wr_ctrl   = hwregs_write && (hwregs_addr == c_addr_ctrl);
    assign w_wr_bright = hwregs_write && (hwregs_addr == c_addr_bright);
    assign w_wr_fade   = hwregs_write && (hwregs_addr == c_addr_fade);

    // A CTRL write coincident with frame_start feeds the swap directly.
    assign w_pending_nxt = w_wr_ctrl ? hwregs_wdata[8 +: BANK_BITS] : r_pending_bank;
    assign w_swap_go     = frame_start && (r_swap_pending || (w_wr_ctrl && hwregs_wdata[16]));

    generate
        if (NUM_BANKS == 1) begin : g_single_bank
            assign w_wr_addr = {{BANK_BITS{1'b0}}, hwregs_addr[PIXEL_BITS+1:2]};
            assign w_rd_addr = {{BANK_BITS{1'b0}}, pixel_in};
        end else begin : g_multi_bank
            assign w_wr_addr = {r_write_bank, hwregs_addr[PIXEL_BITS+1:2]};
            assign w_rd_addr = {r_display_bank, pixel_in};
        end
    endgenerate

    // Fade arithmetic is 9 bits wide so neither direction can wrap.
    assign w_sum  = {1'b0, r_brightness} + {1'b0, r_fade_step};
    assign w_diff = {1'b0, r_brightness} - {1'b0, r_fade_step};

    always_comb begin
        w_fade_next = r_brightness;
        if (r_brightness < r_fade_target) begin
            w_fade_next = (w_sum > {1'b0, r_fade_target}) ? r_fade_target : w_sum[7:0];
        end else if (r_brightness > r_fade_target) begin
            w_fade_next = (w_diff[8] || (w_diff < {1'b0, r_fade_target})) ?
                          r_fade_target : w_diff[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write_bank   <= '0;
            r_pending_bank <= '0;
            r_display_bank <= '0;
            r_swap_pending <= 1'b0;
            r_brightness   <= 8'hFF;
            r_fade_target  <= 8'hFF;
            r_fade_step    <= 8'h00;
        end else begin
            if (w_wr_ctrl) begin
                r_write_bank <= hwregs_wdata[BANK_BITS-1:0];
            end
            r_pending_bank <= w_pending_nxt;
            if (w_swap_go) begin
                r_display_bank <= w_pending_nxt;
                r_swap_pending <= 1'b0;
            end else if (w_wr_ctrl && hwregs_wdata[16]) begin
                r_swap_pending <= 1'b1;
            end
            if (w_wr_bright) begin
                r_brightness  <= hwregs_wdata[7:0];
                r_fade_target <= hwregs_wdata[7:0];
            end else begin
                if (w_wr_fade) begin
                    r_fade_target <= hwregs_wdata[7:0];
                    r_fade_step   <= hwregs_wdata[15:8];
                end
                if (frame_start) begin
                    r_brightness <= w_fade_next;
                end
            end
        end
    end

    // Non-blocking read and write of the same entry yields the old data.
    always_ff @(posedge clock) begin
        if (w_wr_pal) begin
            r_palette[w_wr_addr] <= hwregs_wdata[RGB_BITS-1:0];
        end
        r_entry <= r_palette[w_rd_addr];
    end

    assign w_bright_p1 = {1'b0, r_bright1} + 9'd1;

    generate
        for (genvar ch = 0; ch < 3; ch++) begin : g_chan
            logic [CHAN_BITS+8:0] w_prod;
            assign w_prod = {9'd0, r_entry[ch*CHAN_BITS +: CHAN_BITS]} *
                            {{CHAN_BITS{1'b0}}, w_bright_p1};
            assign w_scaled[ch*CHAN_BITS +: CHAN_BITS] = CHAN_BITS'(w_prod >> 8);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid1    <= 1'b0;
            r_bright1   <= 8'hFF;
            r_rgb_valid <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_valid1    <= pixel_valid;
            r_bright1   <= r_brightness;
            r_rgb_valid <= r_valid1;
            r_rgb       <= r_valid1 ? w_scaled : '0;
        end
    end

`ifdef VGA_PALETTE_READBACK_EN
    logic [31:0] r_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (hwregs_read) begin
            if (!hwregs_addr[11]) begin
                r_rdata <= 32'(r_palette[w_wr_addr]);
            end else begin
                case (hwregs_addr)
                    c_addr_ctrl:   r_rdata <= {15'b0, r_swap_pending, 5'b0, 3'(r_pending_bank),
                                               5'b0, 3'(r_write_bank)};
                    c_addr_bright: r_rdata <= {24'b0, r_brightness};
                    c_addr_fade:   r_rdata <= {16'b0, r_fade_step, r_fade_target};
                    default:       r_rdata <= '0;
                endcase
            end
        end
    end

    assign hwregs_rdata = r_rdata;
`endif

    assign w_disp_bank3 = 3'(r_display_bank);
    assign status       = {3'b000, r_swap_pending, 1'b0, w_disp_bank3};
    assign rgb_valid    = r_rgb_valid;
    assign rgb          = r_rgb;
    assign w_unused     = ^hwregs_wdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_palette_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_palette_banked
// Purpose  : Directed plus randomized bench for vga_palette_banked with a
//            behavioural palette/brightness model and expected-output queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_palette_banked;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        hwregs_write;
    logic [11:0] hwregs_addr;
    logic [31:0] hwregs_wdata;
    logic        frame_start;
    logic        pixel_valid;
    logic [7:0]  pixel_in;
    logic        rgb_valid;
    logic [23:0] rgb;
    logic [7:0]  status;
`ifdef VGA_PALETTE_READBACK_EN
    logic        hwregs_read;
    logic [31:0] hwregs_rdata;
`endif

    vga_palette_banked #(.PIXEL_BITS(8), .NUM_BANKS(2), .CHAN_BITS(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .hwregs_write (hwregs_write),
        .hwregs_addr  (hwregs_addr),
        .hwregs_wdata (hwregs_wdata),
`ifdef VGA_PALETTE_READBACK_EN
        .hwregs_read  (hwregs_read),
        .hwregs_rdata (hwregs_rdata),
`endif
        .frame_start  (frame_start),
        .pixel_valid  (pixel_valid),
        .pixel_in     (pixel_in),
        .rgb_valid    (rgb_valid),
        .rgb          (rgb),
        .status       (status)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [23:0] pal [0:1][0:255];
    int mdb, mpb, msp, mwb, mbr, mtg, mst;
    logic [24:0] expq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] scale(input logic [23:0] c, input int b);
        int r, g, bl;
        r  = (int'(c[23:16]) * (b + 1)) / 256;
        g  = (int'(c[15:8])  * (b + 1)) / 256;
        bl = (int'(c[7:0])   * (b + 1)) / 256;
        return {8'(r), 8'(g), 8'(bl)};
    endfunction

    task automatic model_reset();
        mdb = 0; mpb = 0; msp = 0; mwb = 0;
        mbr = 255; mtg = 255; mst = 0;
        expq.delete();
        expq.push_back(25'd0);
    endtask

    task automatic step(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic fs, input logic pv, input logic [7:0] pi);
        logic [24:0] e;
        int otg, ost;
        bit bw;
        hwregs_write = wr; hwregs_addr = a; hwregs_wdata = d;
        frame_start = fs; pixel_valid = pv; pixel_in = pi;
        e = pv ? {1'b1, scale(pal[mdb][pi], mbr)} : 25'd0;
        expq.push_back(e);
        otg = mtg; ost = mst; bw = 0;
        if (wr) begin
            if (!a[11]) begin
                pal[mwb][a[9:2]] = d[23:0];
            end else if (a == 12'h800) begin
                mwb = int'(d[2:0]) % 2;
                mpb = int'(d[10:8]) % 2;
                if (d[16]) msp = 1;
            end else if (a == 12'h804) begin
                mbr = int'(d[7:0]); mtg = int'(d[7:0]); bw = 1;
            end else if (a == 12'h808) begin
                mtg = int'(d[7:0]); mst = int'(d[15:8]);
            end
        end
        if (fs) begin
            if (msp != 0) begin mdb = mpb; msp = 0; end
            if (!bw) begin
                if (mbr < otg)      mbr = (mbr + ost > otg) ? otg : mbr + ost;
                else if (mbr > otg) mbr = (mbr - ost < otg) ? otg : mbr - ost;
            end
        end
        @(posedge clock);
        #1;
        e = expq.pop_front();
        chk("rgb", 32'(rgb), 32'(e[23:0]));
        chk("rgb_valid", 32'(rgb_valid), 32'(e[24]));
        chk("status", 32'(status), 32'(msp * 16 + mdb));
    endtask

    task automatic wreg(input logic [11:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic pix(input logic [7:0] i);
        step(1'b0, 12'd0, 32'd0, 1'b0, 1'b1, i);
    endtask

    task automatic idle();
        step(1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic rb_check();
`ifdef VGA_PALETTE_READBACK_EN
        hwregs_write = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0;
        hwregs_read = 1'b1; hwregs_addr = 12'h804;
        @(posedge clock);
        #1;
        hwregs_read = 1'b0;
        chk("readback_bright", hwregs_rdata, 32'h000000FF);
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        hwregs_write = 1'b0; hwregs_addr = '0; hwregs_wdata = '0;
        frame_start = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
`ifdef VGA_PALETTE_READBACK_EN
        hwregs_read = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        chk("reset_rgb", 32'(rgb), 32'h0);
        chk("reset_rgb_valid", 32'(rgb_valid), 32'h0);
        chk("reset_status", 32'(status), 32'h0);
        reset_n = 1'b1;
        rb_check();
        model_reset();

        // Latency and identity at full brightness
        wreg(12'h014, 32'h00123456);
        wreg(12'h000, 32'hFFFFFFFF);
        pix(8'd5);
        idle();
        chk("latency_identity", 32'(rgb), 32'h00123456);
        chk("latency_valid", 32'(rgb_valid), 32'h1);
        idle();
        chk("invalid_zero", 32'(rgb), 32'h0);

        // Bank swap on frame_start
        wreg(12'h800, 32'h00000001);
        wreg(12'h014, 32'h00ABCDEF);
        wreg(12'h000, 32'h00FFFFFF);
        wreg(12'h004, 32'h00FF8040);
        wreg(12'h800, 32'h00010100);
        chk("swap_pending_set", 32'(status), 32'h10);
        pix(8'd5);
        idle();
        chk("pre_swap", 32'(rgb), 32'h00123456);
        step(1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 8'd0);
        chk("swap_status", 32'(status), 32'h01);
        pix(8'd5);
        idle();
        chk("post_swap", 32'(rgb), 32'h00ABCDEF);

        // Brightness scaling
        wreg(12'h804, 32'h7F);
        pix(8'd1);
        idle();
        chk("bright_7f", 32'(rgb), 32'h007F4020);
        wreg(12'h804, 32'h00);
        pix(8'd1);
        idle();
        chk("bright_0", 32'(rgb), 32'h0);

        // Fade up, hold at target, then clamp going down
        wreg(12'h804, 32'h10);
        wreg(12'h808, 32'h0860);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 8'd0);
            pix(8'd0);
            idle();
        end
        chk("fade_reach", 32'(rgb), 32'h00606060);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 8'd0);
        end
        pix(8'd0);
        idle();
        chk("fade_hold", 32'(rgb), 32'h00606060);
        wreg(12'h804, 32'h10);
        wreg(12'h808, 32'h2005);
        step(1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 8'd0);
        pix(8'd0);
        idle();
        chk("fade_floor", 32'(rgb), 32'h00050505);

        // Register writes coincident with frame_start
        wreg(12'h804, 32'hFF);
        step(1'b1, 12'h800, 32'h00010000, 1'b1, 1'b0, 8'd0);
        chk("swap_coincident", 32'(status), 32'h00);
        pix(8'd5);
        idle();
        chk("swap_coincident_rgb", 32'(rgb), 32'h00123456);
        wreg(12'h808, 32'h1080);
        step(1'b1, 12'h804, 32'h40, 1'b1, 1'b0, 8'd0);
        pix(8'd0);
        idle();
        chk("bright_coincident", 32'(rgb), 32'h00404040);

        // Fill both banks so every index has defined contents
        for (int b = 0; b < 2; b++) begin
            wreg(12'h800, 32'(b));
            for (int i = 0; i < 256; i++) begin
                wreg({2'b00, 8'(i), 2'b00}, $urandom);
            end
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int k;
            logic        wr;
            logic [11:0] a;
            logic [31:0] d;
            k = $urandom_range(0, 15);
            wr = 1'b0; a = 12'd0; d = $urandom;
            if (k < 4) begin
                wr = 1'b1;
                a = {1'b0, 1'($urandom), 8'($urandom), 2'($urandom)};
            end else if (k == 4) begin
                wr = 1'b1; a = 12'h800;
            end else if (k == 5) begin
                wr = 1'b1; a = 12'h804;
            end else if (k == 6) begin
                wr = 1'b1; a = 12'h808;
            end else if (k == 7) begin
                wr = 1'b1; a = 12'h80C;
            end
            step(wr, a, d, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
        end

        // Reset while pixels are flowing
        pix(8'($urandom));
        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset_rgb", 32'(rgb), 32'h0);
        chk("midreset_valid", 32'(rgb_valid), 32'h0);
        chk("midreset_status", 32'(status), 32'h0);
        #2;
        reset_n = 1'b1;
        rb_check();
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 12'd0, 32'd0, 1'b0, 1'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_palette_banked.md
Name: vga_palette_banked

Overview:
Parametrised, multi-bank palette lookup with frame-synchronised bank swap and a per-frame brightness fade engine. It sits between the pixel fetch pipeline and the VGA output stage. It converts PIXEL_BITS indices into RGB at a fixed 2-cycle latency. Software writes entries and control registers through the hwregs bus.

Parameters:
PIXEL_BITS, 8, index width; each bank holds 2^PIXEL_BITS entries
NUM_BANKS, 2, number of palette banks (power of two, 1..8); BANK_BITS = max(1, clog2(NUM_BANKS))
CHAN_BITS, 8, bits per colour channel; rgb width = 3*CHAN_BITS

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
hwregs_write  in  1  register/palette write strobe
hwregs_addr  in  12  byte address within block
hwregs_wdata  in  32  write data
frame_start  in  1  one-cycle pulse at start of vertical blank
pixel_valid  in  1  pixel_in is a visible pixel
pixel_in  in  PIXEL_BITS  palette index
rgb_valid  out  1  pixel_valid delayed 2 cycles
rgb  out  3*CHAN_BITS  {R,G,B} output; zero when not valid
status  out  8  {3'b0, swap_pending, 1'b0, display_bank[2:0]}, zero-extended

Behaviour:
- Reset (async, reset_n=0): rgb=0, rgb_valid=0, display_bank=0, pending_bank=0, swap_pending=0, write_bank=0, brightness=8'hFF, fade_target=8'hFF, fade_step=0. Palette RAM is not reset (initial contents undefined).
- Address map:
  - addr[11]=0: palette write. Entry = addr[PIXEL_BITS+1:2] in bank write_bank; data = wdata[3*CHAN_BITS-1:0]. Upper data bits and addr[1:0] are ignored.
  - 0x800 CTRL: wdata[2:0]=write_bank, wdata[10:8]=pending_bank. wdata[16]=1 sets swap_pending.
  - 0x804 BRIGHT: wdata[7:0] loads brightness and fade_target immediately, cancelling any fade.
  - 0x808 FADE: wdata[7:0]=fade_target, wdata[15:8]=fade_step.
  - Other addresses: ignored.
  - Bank fields are truncated to BANK_BITS.
- Pixel pipeline, total latency 2 cycles, one pixel per clock, no stalls:
  - Stage 1: entry = RAM[display_bank][pixel_in]; valid1 = pixel_valid.
  - Stage 2: each channel out = (c * (brightness+1)) >> 8, using a CHAN_BITS+9 bit intermediate.
  - brightness=255 is identity; brightness=0 gives 0 for CHAN_BITS≤8.
  - rgb = valid1 ? scaled : 0; rgb_valid = valid1.
  - display_bank and brightness are sampled in stage 1 and carried with the pixel, so a change never splits a pixel.
- Bank swap:
  - On frame_start with swap_pending=1: display_bank<=pending_bank, swap_pending<=0, on the following clock edge.
  - CTRL write with bit16 while pending overwrites pending_bank and keeps swap_pending=1.
  - CTRL write with bit16 in the same cycle as frame_start: the swap uses the newly written pending_bank and swap_pending ends at 0.
- Fade engine, evaluated once per frame_start:
  - If brightness<fade_target: brightness = min(brightness+fade_step, fade_target).
  - If brightness>fade_target: brightness = max(brightness-fade_step, fade_target).
  - 9-bit arithmetic, so there is no wrap.
  - fade_step=0 freezes brightness.
  - A BRIGHT write in the same cycle as frame_start takes priority over the fade step.
- Write to a palette entry in the same cycle as a stage-1 read of that entry: the read returns the old value (read-before-write).
- Reset mid-frame: pipeline flushes, and rgb_valid=0 from reset assertion.

Optional Feature:
Macro VGA_PALETTE_READBACK_EN.
- Defined: adds ports hwregs_read (in, 1) and hwregs_rdata (out, 32).
  - Read data is registered, valid the cycle after hwregs_read.
  - addr[11]=0 returns the palette entry from write_bank, zero-extended.
  - 0x800 returns {15'b0, swap_pending, 5'b0, pending_bank, 5'b0, write_bank}.
  - 0x804 returns current brightness; 0x808 returns {fade_step, fade_target}.
  - Other addresses return 0. hwregs_rdata resets to 0.
  - The palette read port is a second RAM port independent of the pixel port.
- Not defined: no ports or logic added; the block is write-only.

Test Plan:
- Latency/identity: write bank0 entry 5 = 0x123456, then pixel_in=5 with pixel_valid=1 -> rgb=0x123456 and rgb_valid=1 exactly 2 clocks later; pixel_valid=0 -> rgb=0.
- Bank swap: fill bank1 entry 5 = 0xABCDEF, then CTRL=0x10100 -> status swap_pending=1 and output still 0x123456. After frame_start pulse -> 0xABCDEF, swap_pending=0.
- Brightness: BRIGHT=0x7F, entry 0xFF8040 -> rgb=0x7F4020; BRIGHT=0 -> rgb=0x000000.
- Fade: BRIGHT=0x10, FADE=0x0860 (target 0x60, step 8) -> brightness 0x18, 0x20, … reaching 0x60 after 10 frame_starts and holding there. Target 0x05, step 0x20 from 0x10 -> 0x05 in one frame, no underflow.
- Simultaneous events: CTRL swap write coincident with frame_start -> new bank displayed, swap_pending=0. BRIGHT write coincident with frame_start -> the written value wins.
- Reset mid-stream: assert reset_n=0 while pixels flow -> rgb=0 and rgb_valid=0 immediately; after release brightness=0xFF and display_bank=0. With VGA_PALETTE_READBACK_EN, read 0x804 -> 0x000000FF.
